y_sobel: RTL
============

// Module: y_sobel
// PURPOSE
//  3x3 Sobel edge detector on the 8-bit luma stream from the RGB-to-Y stage. Consumes Y with dv/hs/vs.
//  Stores two previous lines in line buffers and forms a 3x3 window.
//  Outputs |Gx|+|Gy| saturated to 8 bits, with control signals delayed to match.
//  Sits between the luma converter and the video output mux.
// PARAMETERS
//  MAX_WIDTH  1920  max active pixels per line; line buffer depth
//  ADDR_W     11    column counter / line buffer address width; 2**ADDR_W >= MAX_WIDTH
// PORTS
//  clk     in   1  pixel clock; all logic on rising edge
//  rst     in   1  synchronous reset, active-high
//  thr_i   in   8  edge threshold; used only with SOBEL_THRESH_EN
//  dv_i    in   1  active pixel valid
//  hs_i    in   1  hsync, passed through
//  vs_i    in   1  vsync, passed through; rising edge starts a frame
//  y_i     in   8  luma, unsigned
//  dv_o    out  1  dv_i delayed 5 cycles
//  hs_o    out  1  hs_i delayed 5 cycles
//  vs_o    out  1  vs_i delayed 5 cycles
//  edge_o  out  8  edge magnitude (or binary edge), aligned with dv_o
// BEHAVIOUR
//  - Reset: all outputs 0; control delay line, col, row and window registers 0.
//    Line buffer RAM contents are not cleared; the border rule masks stale data.
//  - col: increments on each dv_i=1 cycle. Returns to 0 on the cycle after a dv_i falling edge.
//    Saturates at MAX_WIDTH-1.
//  - row: increments on each dv_i falling edge. Saturates at 3.
//    Cleared on a vs_i rising edge (vs_i=1 and the previous vs_i=0).
//    If a vs_i rise and a dv_i fall occur in the same cycle, the clear wins.
//  - Line buffers lb0, lb1: MAX_WIDTH x 8 each, 1-cycle synchronous read, read-before-write.
//    On dv_i, both are read at [col]; y_i is written to lb0[col] and the old lb0[col] to lb1[col].
//    No writes while dv_i=0.
//  - Window: w[r][c], r=0 is current line, c=0 is newest column.
//    On each valid pixel the window shifts by one column and loads {y_i, lb0, lb1} into c=0.
//    The window holds while dv_i=0.
//  - Gx = (w02+2*w12+w22)-(w00+2*w10+w20); Gy = (w20+2*w21+w22)-(w00+2*w01+w02).
//    Both are 11-bit signed, range -1020..1020.
//  - mag = |Gx|+|Gy|, 11-bit unsigned, max 2040; mag>255 saturates to 255.
//  - Border: edge_o=0 when the pixel entered with row<2, col<2, or col at saturation MAX_WIDTH-1.
//    The qualifier is pipelined with the data.
//  - Output position: the result emitted with input pixel (r,c) is the centre (r-1,c-1).
//    The image is shifted by one line and one pixel, with no extra line of latency.
//  - Pipeline, 5 stages: (1) RAM read, col/row capture; (2) window shift; (3) Gx/Gy;
//    (4) abs; (5) sum, saturate/threshold, border mask.
//  - Fixed latency 5 cycles from y_i/dv_i to edge_o/dv_o. The pipeline is always enabled.
//  - edge_o is forced to 0 when the delayed dv is 0.
//  - Reset mid-frame: row=0, so the first two lines after reset output 0.
// CONFIGURATION
//  SOBEL_THRESH_EN defined:
//    edge_o = (sat_mag >= thr_i) ? 8'hFF : 8'h00, registered in stage 5; latency unchanged.
//    With thr_i=0, every non-border valid pixel is 8'hFF.
//  SOBEL_THRESH_EN undefined:
//    edge_o = saturated magnitude; thr_i is unused but the port remains.
// TESTING
//  1 Reset: rst=1 for 3 cycles with random inputs -> all outputs 0 during reset and for 5 cycles after.
//  2 Flat frame: 16x8 frame, y_i=8'h80 everywhere -> edge_o=0 for every dv_o pixel;
//    dv_o/hs_o/vs_o equal the inputs delayed exactly 5 cycles.
//  3 Vertical step: columns 0-7 = 0, columns 8-15 = 100 ->
//    rows>=2 output 255 at input cols 8 and 9 (|Gx|=400 saturated), 0 elsewhere; rows 0-1 all 0.
//  4 Small gradient: y=10*col -> non-border edge_o = |Gx| = 80 (no saturation).
//    With SOBEL_THRESH_EN: thr_i=80 -> 8'hFF, thr_i=81 -> 8'h00.
//  5 Frame restart: assert the vs_i rise in the same cycle as a dv_i fall on line 5 ->
//    row cleared; next two lines output 0, stale line buffer data never appears.
//  6 Width limit: line of MAX_WIDTH+4 pixels -> col holds at MAX_WIDTH-1; those pixels output 0;
//    no write beyond address MAX_WIDTH-1; the next line starts at col 0.

Source files
------------

// File: rtl/y_sobel_if.sv
// Video pixel stream: data valid, syncs and an 8-bit sample.
// Used for both the luma input and the edge output of y_sobel.
interface y_sobel_if;
  logic       dv;
  logic       hs;
  logic       vs;
  logic [7:0] data;

  modport master (
    output dv,
    output hs,
    output vs,
    output data
  );

  modport slave (
    input dv,
    input hs,
    input vs,
    input data
  );
endinterface

// File: rtl/y_sobel.sv
// 3x3 Sobel edge detector on an 8-bit luma stream, fixed 5-cycle latency.
// Optional SOBEL_THRESH_EN turns the saturated magnitude into a binary edge against thr_i.
module y_sobel #(
  parameter int unsigned MAX_WIDTH = 1920,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] thr_i,
  y_sobel_if.slave   vid_i,
  y_sobel_if.master  vid_o
);

  localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(MAX_WIDTH - 1);

  // Control delay lines; bit k is the input delayed k+1 cycles.
  logic [4:0] dv_dly_q, hs_dly_q, vs_dly_q;
  logic [3:0] bord_q;

  logic [ADDR_W-1:0] col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic              dv_fall, vs_rise;

  logic [7:0] lb0_mem [MAX_WIDTH];
  logic [7:0] lb1_mem [MAX_WIDTH];
  logic [7:0] lb0_rd_q, lb1_rd_q;
  logic [7:0] y_s1_q;

  logic [7:0] win_q [3][3];

  logic [9:0]         left_sum, right_sum, top_sum, bot_sum;
  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic signed [10:0] gx_neg, gy_neg;
  logic [9:0]         ax_d, ay_d, ax_q, ay_q;
  logic [10:0]        mag;
  logic [7:0]         sat_mag, res, edge_d, edge_q;

  // Previous-cycle dv/vs are the first taps of the delay lines.
  assign dv_fall = dv_dly_q[0] & ~vid_i.dv;
  assign vs_rise = vid_i.vs & ~vs_dly_q[0];

  always_comb begin
    col_d = col_q;
    if (vid_i.dv) begin
      if (col_q != ColMax) col_d = col_q + 1'b1;
    end else if (dv_fall) begin
      col_d = '0;
    end
  end

  always_comb begin
    row_d = row_q;
    if (vs_rise) begin
      row_d = '0;
    end else if (dv_fall && row_q != 2'd3) begin
      row_d = row_q + 2'd1;
    end
  end

  // Line buffers: read-before-write, lb0 cascades its old word into lb1.
  always_ff @(posedge clk) begin
    if (vid_i.dv) begin
      lb0_rd_q       <= lb0_mem[col_q];
      lb1_rd_q       <= lb1_mem[col_q];
      lb0_mem[col_q] <= vid_i.data;
      lb1_mem[col_q] <= lb0_mem[col_q];
    end
  end

  always_comb begin
    left_sum  = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
    right_sum = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    top_sum   = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
    bot_sum   = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
    gx_d      = $signed({1'b0, left_sum}) - $signed({1'b0, right_sum});
    gy_d      = $signed({1'b0, top_sum}) - $signed({1'b0, bot_sum});
  end

  always_comb begin
    gx_neg = -gx_q;
    gy_neg = -gy_q;
    ax_d   = gx_q[10] ? gx_neg[9:0] : gx_q[9:0];
    ay_d   = gy_q[10] ? gy_neg[9:0] : gy_q[9:0];
  end

  always_comb begin
    mag     = {1'b0, ax_q} + {1'b0, ay_q};
    sat_mag = (|mag[10:8]) ? 8'hFF : mag[7:0];
  end

`ifdef SOBEL_THRESH_EN
  assign res = (sat_mag >= thr_i) ? 8'hFF : 8'h00;
`else
  logic unused_thr;
  assign unused_thr = ^thr_i;
  assign res        = sat_mag;
`endif

  assign edge_d = (dv_dly_q[3] && !bord_q[3]) ? res : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_dly_q <= '0;
      hs_dly_q <= '0;
      vs_dly_q <= '0;
      bord_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      y_s1_q   <= '0;
      win_q    <= '{default: '0};
      gx_q     <= '0;
      gy_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      edge_q   <= '0;
    end else begin
      dv_dly_q <= {dv_dly_q[3:0], vid_i.dv};
      hs_dly_q <= {hs_dly_q[3:0], vid_i.hs};
      vs_dly_q <= {vs_dly_q[3:0], vid_i.vs};
      bord_q   <= {bord_q[2:0], (row_q < 2'd2) || (col_q < ADDR_W'(2)) || (col_q == ColMax)};
      col_q    <= col_d;
      row_q    <= row_d;
      y_s1_q   <= vid_i.data;
      if (dv_dly_q[0]) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][2] <= win_q[r][1];
          win_q[r][1] <= win_q[r][0];
        end
        win_q[0][0] <= y_s1_q;
        win_q[1][0] <= lb0_rd_q;
        win_q[2][0] <= lb1_rd_q;
      end
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      edge_q   <= edge_d;
    end
  end

  assign vid_o.dv   = dv_dly_q[4];
  assign vid_o.hs   = hs_dly_q[4];
  assign vid_o.vs   = vs_dly_q[4];
  assign vid_o.data = edge_q;

endmodule
